// File: rtl/busmaster.sv
// busmaster: 68030 bus master engine. Takes one read/write operand command,
// wins the bus through BR/BG/BGACK and runs one or more asynchronous
// AS/DS cycles. Port size comes from DSACK or STERM at termination.
// BERR aborts the operand. All bus-facing outputs come straight from flops.
module busmaster #(
    parameter logic [2:0] FC_SPACE = 3'b101
) (
    input  logic        CPU_CLK,
    input  logic        RESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rnw,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        nBR,
    input  logic        nBG,
    output logic        nBGACK,
    output logic        BUS_OE,
    output logic [31:0] ADDR,
    output logic [1:0]  SIZ,
    output logic [2:0]  FC,
    output logic        RnW,
    output logic        nAS_O,
    output logic        nDS_O,
    input  logic        nAS_I,
    output logic [31:0] DATA_O,
    output logic        DATA_OE,
    input  logic [31:0] DATA_I,
    input  logic [1:0]  nDSACK,
    input  logic        nSTERM,
    input  logic        nBERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_GRANT,
        S_ADDR,
        S_STRB,
        S_WAIT,
        S_END,
        S_RELEASE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Operand bookkeeping
    logic [31:0] r_addr;      // address of the current sub-cycle (drives ADDR)
    logic [2:0]  r_rem;       // bytes still to move, 1..4 (low bits drive SIZ)
    logic [2:0]  r_moved;     // bytes moved by the sub-cycle that just ended
    logic [31:0] r_wdata;     // right-justified write operand
    logic [31:0] r_acc;       // right-justified read accumulator
    logic        r_rnw;
    logic        r_err;

    // Registered outputs
    logic        r_cmd_ready;
    logic        r_nbr;
    logic        r_nbgack;
    logic        r_bus_oe;
    logic        r_nas;
    logic        r_nds;
    logic        r_data_oe;
    logic [31:0] r_data_o;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    // Combinational helpers
    logic        w_handshake;
    logic        w_illegal;
    logic [2:0]  w_size_bytes;
    logic        w_term;
    logic        w_bus_free;
    logic [2:0]  w_port;
    logic [1:0]  w_offset;
    logic [2:0]  w_avail;
    logic [2:0]  w_moved;
    logic [31:0] w_acc_next;
    logic        w_err_out;

    // Places the remaining low bytes of the operand on the lanes so that any
    // port width and byte offset finds its bytes where it expects them.
    function automatic logic [31:0] place_wdata(input logic [31:0] d, input logic [2:0] rem);
        case (rem)
            3'd1:    place_wdata = {4{d[7:0]}};
            3'd2:    place_wdata = {2{d[15:0]}};
            3'd3:    place_wdata = {d[23:16], d[23:0]};
            default: place_wdata = d;
        endcase
    endfunction

    // Lane 0 is the most significant byte of the data bus.
    function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] lane);
        case (lane)
            2'd0:    lane_byte = d[31:24];
            2'd1:    lane_byte = d[23:16];
            2'd2:    lane_byte = d[15:8];
            default: lane_byte = d[7:0];
        endcase
    endfunction

    assign w_handshake = (r_state == S_IDLE) && cmd_valid;
    assign w_illegal   = (cmd_size == 2'b11)
                       || ((cmd_size == 2'b00) && (cmd_addr[1:0] != 2'b00))
                       || ((cmd_size == 2'b10) && cmd_addr[0]);
    assign w_term      = !nBERR || !nSTERM || (nDSACK != 2'b11);
    assign w_bus_free  = !nBG && nAS_I && (nDSACK == 2'b11) && nSTERM;
    assign w_err_out   = (r_state == S_IDLE) ? w_illegal : r_err;

    // Command size code to byte count
    always_comb begin
        case (cmd_size)
            2'b01:   w_size_bytes = 3'd1;
            2'b10:   w_size_bytes = 3'd2;
            default: w_size_bytes = 3'd4;
        endcase
    end

    // Port width from the termination, then bytes this sub-cycle can move
    always_comb begin
        w_port = 3'd1;
        if (!nSTERM || (nDSACK == 2'b00))
            w_port = 3'd4;
        else if (nDSACK == 2'b01)
            w_port = 3'd2;

        w_offset = 2'd0;
        if (w_port == 3'd4)
            w_offset = r_addr[1:0];
        else if (w_port == 3'd2)
            w_offset = {1'b0, r_addr[0]};

        w_avail = w_port - {1'b0, w_offset};
        w_moved = (r_rem < w_avail) ? r_rem : w_avail;
    end

    // Shift the bytes of this sub-cycle into the read accumulator
    always_comb begin
        w_acc_next = r_acc;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < w_moved)
                w_acc_next = {w_acc_next[23:0], lane_byte(DATA_I, w_offset + 2'(i))};
        end
    end

    // State register
    always_ff @(posedge CPU_CLK) begin
        if (RESET)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (cmd_valid) w_state_next = w_illegal ? S_RELEASE : S_REQ;
            S_REQ:     if (w_bus_free) w_state_next = S_GRANT;
            S_GRANT:   w_state_next = S_ADDR;
            S_ADDR:    w_state_next = S_STRB;
            S_STRB:    w_state_next = S_WAIT;
            S_WAIT:    if (w_term) w_state_next = S_END;
            S_END: begin
                if ((nDSACK == 2'b11) && nSTERM)
                    w_state_next = (!r_err && (r_rem != r_moved)) ? S_ADDR : S_RELEASE;
            end
            S_RELEASE: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Operand datapath: latch on handshake, accumulate on termination,
    // advance address/count when another sizing sub-cycle follows
    always_ff @(posedge CPU_CLK) begin
        if (RESET) begin
            r_addr   <= 32'd0;
            r_rem    <= 3'd0;
            r_moved  <= 3'd0;
            r_wdata  <= 32'd0;
            r_acc    <= 32'd0;
            r_rnw    <= 1'b1;
            r_err    <= 1'b0;
            r_data_o <= 32'd0;
        end else begin
            if (w_handshake) begin
                r_addr   <= cmd_addr;
                r_rem    <= w_size_bytes;
                r_moved  <= 3'd0;
                r_wdata  <= cmd_wdata;
                r_acc    <= 32'd0;
                r_rnw    <= cmd_rnw;
                r_err    <= w_illegal;
                r_data_o <= place_wdata(cmd_wdata, w_size_bytes);
            end
            if ((r_state == S_WAIT) && w_term) begin
                r_moved <= w_moved;
                if (!nBERR)
                    r_err <= 1'b1;
                else
                    r_acc <= w_acc_next;
            end
            if ((r_state == S_END) && (w_state_next == S_ADDR)) begin
                r_addr   <= r_addr + {29'd0, r_moved};
                r_rem    <= r_rem - r_moved;
                r_data_o <= place_wdata(r_wdata, r_rem - r_moved);
            end
        end
    end

    // Strobes, enables and response registered from the next state
    always_ff @(posedge CPU_CLK) begin
        if (RESET) begin
            r_cmd_ready <= 1'b1;
            r_nbr       <= 1'b1;
            r_nbgack    <= 1'b1;
            r_bus_oe    <= 1'b0;
            r_nas       <= 1'b1;
            r_nds       <= 1'b1;
            r_data_oe   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_cmd_ready <= (w_state_next == S_IDLE);
            r_nbr       <= (w_state_next != S_REQ);
            r_nbgack    <= !(w_state_next inside {S_GRANT, S_ADDR, S_STRB, S_WAIT, S_END});
            r_bus_oe    <= (w_state_next inside {S_ADDR, S_STRB, S_WAIT, S_END});
            r_nas       <= !(w_state_next inside {S_STRB, S_WAIT});
            r_nds       <= !(((w_state_next == S_STRB) && r_rnw) || (w_state_next == S_WAIT));
            r_data_oe   <= !r_rnw && (w_state_next inside {S_ADDR, S_STRB, S_WAIT, S_END});
            r_rsp_valid <= (w_state_next == S_RELEASE);
            r_rsp_err   <= (w_state_next == S_RELEASE) && w_err_out;
            if (w_state_next == S_RELEASE)
                r_rsp_rdata <= r_acc;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign nBR       = r_nbr;
    assign nBGACK    = r_nbgack;
    assign BUS_OE    = r_bus_oe;
    assign ADDR      = r_addr;
    assign SIZ       = r_rem[1:0];
    assign FC        = FC_SPACE;
    assign RnW       = r_rnw;
    assign nAS_O     = r_nas;
    assign nDS_O     = r_nds;
    assign DATA_O    = r_data_o;
    assign DATA_OE   = r_data_oe;

endmodule

// File: tb/tb_busmaster.sv
// tb_busmaster: directed steps with a scoreboard of expected bus cycles and
// expected responses; the bench acts as bus arbiter and slave responder.
module tb_busmaster;

    localparam logic [2:0] FC_EXP = 3'b101;

    logic        CPU_CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rnw = 1'b1;
    logic [1:0]  cmd_size = 2'b00;
    logic [31:0] cmd_addr = 32'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        nBR;
    logic        nBG = 1'b0;
    logic        nBGACK;
    logic        BUS_OE;
    logic [31:0] ADDR;
    logic [1:0]  SIZ;
    logic [2:0]  FC;
    logic        RnW;
    logic        nAS_O;
    logic        nDS_O;
    logic        nAS_I = 1'b1;
    logic [31:0] DATA_O;
    logic        DATA_OE;
    logic [31:0] DATA_I = 32'd0;
    logic [1:0]  nDSACK = 2'b11;
    logic        nSTERM = 1'b1;
    logic        nBERR = 1'b1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  siz;
        logic        rnw;
        logic [31:0] wdata;
        logic [31:0] drive;
        logic        berr;
    } cyc_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rdata;
        int          lat;
    } rsp_t;

    cyc_t cyc_q[$];
    rsp_t rsp_q[$];

    always #20 CPU_CLK = ~CPU_CLK;

    busmaster #(.FC_SPACE(3'b101)) dut (
        .CPU_CLK   (CPU_CLK),
        .RESET     (RESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rnw   (cmd_rnw),
        .cmd_size  (cmd_size),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .nBR       (nBR),
        .nBG       (nBG),
        .nBGACK    (nBGACK),
        .BUS_OE    (BUS_OE),
        .ADDR      (ADDR),
        .SIZ       (SIZ),
        .FC        (FC),
        .RnW       (RnW),
        .nAS_O     (nAS_O),
        .nDS_O     (nDS_O),
        .nAS_I     (nAS_I),
        .DATA_O    (DATA_O),
        .DATA_OE   (DATA_OE),
        .DATA_I    (DATA_I),
        .nDSACK    (nDSACK),
        .nSTERM    (nSTERM),
        .nBERR     (nBERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_cyc(input logic [31:0] addr, input logic [1:0] siz, input logic rnw,
                            input logic [31:0] wdata, input logic [31:0] drive, input logic berr);
        cyc_t c;
        c.addr = addr; c.siz = siz; c.rnw = rnw; c.wdata = wdata; c.drive = drive; c.berr = berr;
        cyc_q.push_back(c);
    endtask

    task automatic push_rsp(input logic [31:0] rdata, input logic err, input logic chk_rdata, input int lat);
        rsp_t r;
        r.rdata = rdata; r.err = err; r.chk_rdata = chk_rdata; r.lat = lat;
        rsp_q.push_back(r);
    endtask

    // Issue one command and act as responder until the completion pulse.
    // term: 0 = DSACK 32-bit, 1 = DSACK 16-bit, 2 = DSACK 8-bit, 3 = STERM
    task automatic run_cmd(input logic rnw, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input int term, input logic exp_br);
        cyc_t c;
        rsp_t r;
        int   k;
        bit   done;
        bit   prev_as;
        bit   active;
        bit   saw_br;
        @(negedge CPU_CLK);
        chk("cmd_ready_before", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_rnw = rnw; cmd_size = size; cmd_addr = addr; cmd_wdata = wdata;
        @(posedge CPU_CLK);
        k = 0; done = 0; prev_as = 1; active = 0; saw_br = 0;
        while (!done && k < 200) begin
            @(negedge CPU_CLK);
            k++;
            cmd_valid = 1'b0;
            if (!nBR) saw_br = 1;
            if (!nAS_O && prev_as) begin
                chk("cycle_expected", cyc_q.size() != 0, 1'b1);
                if (cyc_q.size() != 0) begin
                    c = cyc_q.pop_front();
                    chk("addr", ADDR, c.addr);
                    chk("siz", {30'd0, SIZ}, {30'd0, c.siz});
                    chk("rnw", RnW, c.rnw);
                    chk("fc", {29'd0, FC}, {29'd0, FC_EXP});
                    chk("bus_oe", BUS_OE, 1'b1);
                    chk("nbgack_low", nBGACK, 1'b0);
                    chk("nds_strb", nDS_O, !c.rnw);
                    chk("data_oe", DATA_OE, !c.rnw);
                    if (!c.rnw) chk("data_o", DATA_O, c.wdata);
                    DATA_I = c.drive;
                    if (c.berr) begin
                        nBERR = 1'b0; nDSACK = 2'b00;
                    end else begin
                        case (term)
                            0:       nDSACK = 2'b00;
                            1:       nDSACK = 2'b01;
                            2:       nDSACK = 2'b10;
                            default: nSTERM = 1'b0;
                        endcase
                    end
                    active = 1;
                end
            end else if (nAS_O && active) begin
                nDSACK = 2'b11; nSTERM = 1'b1; nBERR = 1'b1; DATA_I = 32'd0;
                active = 0;
            end
            prev_as = nAS_O;
            if (rsp_valid) begin
                done = 1;
                chk("rsp_expected", rsp_q.size() != 0, 1'b1);
                if (rsp_q.size() != 0) begin
                    r = rsp_q.pop_front();
                    chk("rsp_err", rsp_err, r.err);
                    if (r.chk_rdata) chk("rsp_rdata", rsp_rdata, r.rdata);
                    chk("latency", k, r.lat);
                    chk("nbgack_release", nBGACK, 1'b1);
                    chk("bus_oe_release", BUS_OE, 1'b0);
                    chk("data_oe_release", DATA_OE, 1'b0);
                end
                $display("txn rnw=%0d size=%0d addr=%h wdata=%h -> rdata=%h err=%0d after %0d cycles",
                         rnw, size, addr, wdata, rsp_rdata, rsp_err, k);
            end
        end
        chk("rsp_seen", done, 1'b1);
        chk("cycles_left", cyc_q.size(), 0);
        chk("br_used", saw_br, exp_br);
        nDSACK = 2'b11; nSTERM = 1'b1; nBERR = 1'b1;
        @(negedge CPU_CLK);
        chk("rsp_one_pulse", rsp_valid, 1'b0);
        chk("cmd_ready_after", cmd_ready, 1'b1);
    endtask

    task automatic chk_idle(input string pfx);
        chk({pfx, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({pfx, "_nbr"}, nBR, 1'b1);
        chk({pfx, "_nbgack"}, nBGACK, 1'b1);
        chk({pfx, "_nas"}, nAS_O, 1'b1);
        chk({pfx, "_nds"}, nDS_O, 1'b1);
        chk({pfx, "_bus_oe"}, BUS_OE, 1'b0);
        chk({pfx, "_data_oe"}, DATA_OE, 1'b0);
        chk({pfx, "_rsp_valid"}, rsp_valid, 1'b0);
    endtask

    initial begin
        bit seen;

        // Reset state
        repeat (3) @(posedge CPU_CLK);
        @(negedge CPU_CLK);
        RESET = 1'b0;
        @(negedge CPU_CLK);
        chk_idle("reset");
        chk("reset_rsp_err", rsp_err, 1'b0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_addr", ADDR, 32'd0);
        chk("reset_siz", {30'd0, SIZ}, 32'd0);
        chk("reset_fc", {29'd0, FC}, {29'd0, FC_EXP});
        chk("reset_rnw", RnW, 1'b1);
        chk("reset_data_o", DATA_O, 32'd0);

        // Long read, 32-bit port, best-case latency
        push_cyc(32'h0000_1000, 2'b00, 1'b1, 32'd0, 32'hDEAD_BEEF, 1'b0);
        push_rsp(32'hDEAD_BEEF, 1'b0, 1'b1, 7);
        run_cmd(1'b1, 2'b00, 32'h0000_1000, 32'd0, 0, 1'b1);

        // Long read, 16-bit port: two sizing cycles
        push_cyc(32'hFFF0_0000, 2'b00, 1'b1, 32'd0, 32'h1234_ABCD, 1'b0);
        push_cyc(32'hFFF0_0002, 2'b10, 1'b1, 32'd0, 32'h5678_EF01, 1'b0);
        push_rsp(32'h1234_5678, 1'b0, 1'b1, 11);
        run_cmd(1'b1, 2'b00, 32'hFFF0_0000, 32'd0, 1, 1'b1);

        // Long write, 8-bit port: four sizing cycles
        push_cyc(32'hFFE0_0000, 2'b00, 1'b0, 32'hA1B2_C3D4, 32'd0, 1'b0);
        push_cyc(32'hFFE0_0001, 2'b11, 1'b0, 32'hB2B2_C3D4, 32'd0, 1'b0);
        push_cyc(32'hFFE0_0002, 2'b10, 1'b0, 32'hC3D4_C3D4, 32'd0, 1'b0);
        push_cyc(32'hFFE0_0003, 2'b01, 1'b0, 32'hD4D4_D4D4, 32'd0, 1'b0);
        push_rsp(32'd0, 1'b0, 1'b0, 19);
        run_cmd(1'b0, 2'b00, 32'hFFE0_0000, 32'hA1B2_C3D4, 2, 1'b1);

        // Byte write at offset 3, STERM termination
        push_cyc(32'hFF80_0003, 2'b01, 1'b0, 32'h5A5A_5A5A, 32'd0, 1'b0);
        push_rsp(32'd0, 1'b0, 1'b0, 7);
        run_cmd(1'b0, 2'b01, 32'hFF80_0003, 32'h0000_005A, 3, 1'b1);

        // Word read at odd halfword of a 32-bit port
        push_cyc(32'h0000_2002, 2'b10, 1'b1, 32'd0, 32'h1111_9ABC, 1'b0);
        push_rsp(32'h0000_9ABC, 1'b0, 1'b1, 7);
        run_cmd(1'b1, 2'b10, 32'h0000_2002, 32'd0, 0, 1'b1);

        // Bus error in the second sub-cycle of a 16-bit port long read
        push_cyc(32'hFFF0_0100, 2'b00, 1'b1, 32'd0, 32'h1111_2222, 1'b0);
        push_cyc(32'hFFF0_0102, 2'b10, 1'b1, 32'd0, 32'h3333_4444, 1'b1);
        push_rsp(32'd0, 1'b1, 1'b0, 11);
        run_cmd(1'b1, 2'b00, 32'hFFF0_0100, 32'd0, 1, 1'b1);

        // Illegal size and misaligned long: immediate error, no bus request
        push_rsp(32'd0, 1'b1, 1'b0, 1);
        run_cmd(1'b1, 2'b11, 32'h0000_3000, 32'd0, 0, 1'b0);
        push_rsp(32'd0, 1'b1, 1'b0, 1);
        run_cmd(1'b0, 2'b00, 32'h0000_3002, 32'h0BAD_0BAD, 0, 1'b0);

        // Arbitration: no grant for 10 cycles, then grant and reset during WAIT
        nBG = 1'b1;
        @(negedge CPU_CLK);
        cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_size = 2'b00; cmd_addr = 32'h0000_4000;
        @(posedge CPU_CLK);
        for (int i = 0; i < 10; i++) begin
            @(negedge CPU_CLK);
            cmd_valid = 1'b0;
            chk("arb_nbr_low", nBR, 1'b0);
            chk("arb_bus_oe", BUS_OE, 1'b0);
        end
        nBG = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CPU_CLK);
            if (!nAS_O) seen = 1;
        end
        chk("arb_strobe_seen", seen, 1'b1);
        @(negedge CPU_CLK);
        chk("wait_nds", nDS_O, 1'b0);
        chk("wait_nbgack", nBGACK, 1'b0);
        RESET = 1'b1;
        @(negedge CPU_CLK);
        chk_idle("midreset");
        RESET = 1'b0;
        @(negedge CPU_CLK);

        // Recovery after mid-cycle reset
        push_cyc(32'h0000_5000, 2'b00, 1'b1, 32'd0, 32'hCAFE_F00D, 1'b0);
        push_rsp(32'hCAFE_F00D, 1'b0, 1'b1, 7);
        run_cmd(1'b1, 2'b00, 32'h0000_5000, 32'd0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
